iserdes_1_to_4_align: RTL and testbench
=======================================

Name: iserdes_1_to_4_align

Overview:
Fabric-side receive deserializer, the receive-direction counterpart of the 4:1 output serializer path. It samples one serial bit per enabled CLK edge and assembles WIDTH-bit parallel words with a one-cycle valid strobe. It recovers the word boundary by bit-slipping until a known training word is seen on several consecutive words. It sits between the input buffer of a serial pin and fabric logic that consumes parallel words.

Parameters:
WIDTH, 4, word width in bits (legal 3..10)
PATTERN, 4'b0011, training word expected on Q when aligned (WIDTH bits; Q[0] = first bit in time)
MATCH_WORDS, 4, consecutive matching words required to declare lock (1..15)

Ports:
CLK  input  1  sole clock; all state updates on rising edge
RST  input  1  asynchronous active-low reset; 0 resets all state immediately, release is synchronous to CLK
D  input  1  serial data, sampled on CLK when EN=1
EN  input  1  sample enable; EN=0 freezes all state (no shift, no count, no FSM advance)
ALIGN_START  input  1  single-cycle pulse: clear slip/match counters and enter HUNT
Q  output  WIDTH  parallel word, registered; Q[0] = earliest received bit
DATA_VALID  output  1  one-cycle pulse when Q is updated
ALIGNED  output  1  high while FSM is in LOCKED
ALIGN_FAIL  output  1  high while FSM is in FAIL
SLIP_COUNT  output  clog2(WIDTH)+1  slips issued since the last ALIGN_START

Behaviour:
- Reset (RST=0): Q=0, DATA_VALID=0, ALIGNED=0, ALIGN_FAIL=0, SLIP_COUNT=0, shift register=0, bit counter=0, match count=0, FSM=IDLE.
- Shift: on EN=1, sreg <= {D, sreg[WIDTH-1:1]}.
- Bit counter cnt counts 0..WIDTH-1 on EN=1. When EN=1 and cnt=WIDTH-1: Q <= {D, sreg[WIDTH-1:1]}, DATA_VALID=1 on the next cycle, cnt <= 0.
- Latency: Q and DATA_VALID appear one cycle after the edge that samples the word's last bit.
- DATA_VALID is 0 in all other cycles, including EN=0 cycles. Words are delivered in every FSM state.
- Slip: a slip request holds cnt for exactly one EN=1 cycle. The shift still occurs. This moves the word boundary one bit later in time.
- If a slip and a word-complete fall on the same cycle, the slip wins: no word is delivered that cycle, and the word completes one bit later.
- FSM states: IDLE, HUNT, SLIP, DISCARD, LOCKED, FAIL.
- IDLE: waits for ALIGN_START.
- HUNT: on each DATA_VALID:
  - Q==PATTERN: increment match count; reaching MATCH_WORDS -> LOCKED.
  - Q!=PATTERN with SLIP_COUNT<WIDTH: clear match count, go to SLIP.
  - Q!=PATTERN with SLIP_COUNT==WIDTH: go to FAIL.
- SLIP: issue one slip on the next EN=1 cycle, increment SLIP_COUNT, go to DISCARD.
- DISCARD: ignore the next DATA_VALID word (a partial word straddling the old boundary), then return to HUNT.
- LOCKED: ALIGNED=1. No further slips. Stays locked until ALIGN_START or reset.
- FAIL: ALIGN_FAIL=1. Stays until ALIGN_START or reset.
- ALIGN_START in any state, including mid-slip: next cycle FSM=HUNT, SLIP_COUNT=0, match count=0, ALIGNED=0, ALIGN_FAIL=0. A pending slip is cancelled. cnt and sreg are not reset.
- ALIGN_START coinciding with DATA_VALID: ALIGN_START has priority, and that word is not evaluated.
- SLIP_COUNT saturates at WIDTH.
- RST asserted mid-operation: all outputs go to reset values asynchronously. After release the FSM is in IDLE (a new ALIGN_START is required).

Test Plan:
1. Reset/idle: hold RST=0 with D toggling -> Q=0, DATA_VALID=0, ALIGNED=0, ALIGN_FAIL=0, SLIP_COUNT=0. Release RST, send bits 1,0,1,1 with EN=1 -> one cycle after the 4th sample edge, Q=4'b1101 and DATA_VALID pulses for one cycle; a pulse follows every 4 EN cycles thereafter.
2. One-slip lock: after reset, send repeating stream starting 0,1,1,0,0,1,1,0..., pulse ALIGN_START -> first word 4'b0110 mismatches, one slip; after the discarded word, Q=4'b0011 repeats; ALIGNED=1 after 4 matches; SLIP_COUNT=1.
3. Three-slip lock: stream starting 1,0,0,1,1,0,0,1... -> words 1001, then 1100, then 0110 each mismatch; ALIGNED=1 with SLIP_COUNT=3; Q stable at 4'b0011.
4. Fail: constant D=1, ALIGN_START -> exactly 4 slips, then on the next mismatch ALIGN_FAIL=1, ALIGNED=0, SLIP_COUNT=4; no further slips occur.
5. EN gaps: insert random EN=0 cycles during scenario 3 -> identical word sequence and final SLIP_COUNT=3; DATA_VALID never asserted in an EN=0-following idle cycle without word completion.
6. Restart/reset: pulse ALIGN_START while in LOCKED, then again in SLIP -> SLIP_COUNT=0, ALIGNED=0 next cycle, hunt resumes and relocks. Assert RST=0 mid-HUNT -> outputs clear immediately; FSM remains IDLE after release until ALIGN_START.

Source files
------------

// File: rtl/iserdes_1_to_4_align.sv
// ---------------------------------------------------------------------------
// iserdes_1_to_4_align
//
// Receive-side deserializer with training-word alignment. One serial bit is
// taken on every rising CLK edge with EN=1 and assembled into WIDTH-bit words,
// earliest bit in Q[0]. The word boundary is found by slipping one bit at a
// time until PATTERN is seen on MATCH_WORDS consecutive words.
//
// Parameters
//   WIDTH        word width in bits, legal 3..10
//   PATTERN      training word as it should appear on Q once aligned
//   MATCH_WORDS  consecutive matching words needed to declare lock, 1..15
//
// Ports
//   CLK          clock, all state changes on the rising edge
//   RST          asynchronous active-low reset
//   D            serial data in
//   EN           sample enable; 0 freezes shifting, counting and slipping
//   ALIGN_START  one-cycle pulse that (re)starts the alignment hunt
//   Q            registered parallel word, Q[0] = earliest bit
//   DATA_VALID   one-cycle pulse in the cycle Q carries a new word
//   ALIGNED      high while locked
//   ALIGN_FAIL   high after every bit offset was tried without success
//   SLIP_COUNT   slips issued since the last ALIGN_START, saturates at WIDTH
// ---------------------------------------------------------------------------
module iserdes_1_to_4_align #(
    parameter int unsigned      WIDTH       = 4,
    parameter logic [WIDTH-1:0] PATTERN     = WIDTH'(4'b0011),
    parameter int unsigned      MATCH_WORDS = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   D,
    input  logic                   EN,
    input  logic                   ALIGN_START,
    output logic [WIDTH-1:0]       Q,
    output logic                   DATA_VALID,
    output logic                   ALIGNED,
    output logic                   ALIGN_FAIL,
    output logic [$clog2(WIDTH):0] SLIP_COUNT
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam int unsigned SlpW = CntW + 1;
    localparam int unsigned MchW = $clog2(MATCH_WORDS + 1);

    localparam logic [CntW-1:0] CntLast   = CntW'(WIDTH - 1);
    localparam logic [SlpW-1:0] SlipMax   = SlpW'(WIDTH);
    localparam logic [MchW-1:0] MatchLast = MchW'(MATCH_WORDS - 1);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StHunt    = 3'd1;
    localparam logic [2:0] StSlip    = 3'd2;
    localparam logic [2:0] StDiscard = 3'd3;
    localparam logic [2:0] StLocked  = 3'd4;
    localparam logic [2:0] StFail    = 3'd5;

    // Only the WIDTH-1 most recent bits are kept; the newest bit comes
    // straight from D when a word is captured, so the oldest stage of a full
    // WIDTH-bit shift register would never be read.
    logic [WIDTH-2:0] hist;
    logic [WIDTH-1:0] shifted;
    logic [CntW-1:0]  cnt;

    logic [2:0]       state;
    logic [2:0]       state_next;
    logic [MchW-1:0]  match_cnt;
    logic [MchW-1:0]  match_next;
    logic [SlpW-1:0]  slip_next;

    logic             slip;
    logic             word_done;

    assign shifted = {D, hist};

    // A slip is issued on the first enabled cycle spent in SLIP. ALIGN_START
    // cancels it. Holding cnt for that one cycle pushes the boundary one bit
    // later; if it lands on the word-complete cycle, that word is deferred.
    assign slip      = EN && (state == StSlip) && !ALIGN_START;
    assign word_done = EN && (cnt == CntLast) && !slip;

    // -----------------------------------------------------------------------
    // Datapath: shift register, bit counter, output word and valid strobe
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hist       <= '0;
            cnt        <= '0;
            Q          <= '0;
            DATA_VALID <= 1'b0;
        end else begin
            // Updated every cycle so the strobe is a single-cycle pulse even
            // when EN drops right after a word completes.
            DATA_VALID <= word_done;
            if (EN) begin
                hist <= shifted[WIDTH-1:1];
                if (!slip) begin
                    cnt <= (cnt == CntLast) ? '0 : cnt + 1'b1;
                end
            end
            if (word_done) begin
                Q <= shifted;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Alignment FSM
    // -----------------------------------------------------------------------
    // Words are judged in the cycle DATA_VALID is high, whatever EN is doing
    // then, so an EN gap right after a word never loses its evaluation.
    always_comb begin
        state_next = state;
        match_next = match_cnt;
        slip_next  = SLIP_COUNT;

        if (ALIGN_START) begin
            // Overrides everything, including a word presented this cycle.
            state_next = StHunt;
            match_next = '0;
            slip_next  = '0;
        end else begin
            case (state)
                StHunt: begin
                    if (DATA_VALID) begin
                        if (Q == PATTERN) begin
                            match_next = match_cnt + 1'b1;
                            if (match_cnt == MatchLast) begin
                                state_next = StLocked;
                            end
                        end else if (SLIP_COUNT < SlipMax) begin
                            match_next = '0;
                            state_next = StSlip;
                        end else begin
                            state_next = StFail;
                        end
                    end
                end
                StSlip: begin
                    if (EN) begin
                        slip_next  = (SLIP_COUNT == SlipMax) ? SLIP_COUNT : SLIP_COUNT + 1'b1;
                        state_next = StDiscard;
                    end
                end
                StDiscard: begin
                    // The first word after a slip straddles the old boundary.
                    if (DATA_VALID) begin
                        state_next = StHunt;
                    end
                end
                default: begin
                    // IDLE, LOCKED and FAIL only leave on ALIGN_START.
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= StIdle;
            match_cnt  <= '0;
            SLIP_COUNT <= '0;
        end else begin
            state      <= state_next;
            match_cnt  <= match_next;
            SLIP_COUNT <= slip_next;
        end
    end

    assign ALIGNED    = (state == StLocked);
    assign ALIGN_FAIL = (state == StFail);

endmodule

// File: tb/tb_iserdes_1_to_4_align.sv
// ---------------------------------------------------------------------------
// tb_iserdes_1_to_4_align
//
// Directed bench for iserdes_1_to_4_align with default parameters
// (WIDTH=4, PATTERN=4'b0011, MATCH_WORDS=4). Expected words are queued when a
// scenario starts and popped as the DUT delivers them. Inputs change and
// outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_iserdes_1_to_4_align;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       D = 1'b0;
    logic       EN = 1'b0;
    logic       ALIGN_START = 1'b0;
    logic [3:0] Q;
    logic       DATA_VALID;
    logic       ALIGNED;
    logic       ALIGN_FAIL;
    logic [2:0] SLIP_COUNT;

    int         errors = 0;
    int         checks = 0;
    logic [3:0] exp_q[$];
    bit         sb_on = 1'b0;
    bit         gaps = 1'b0;
    int         dv_count = 0;
    int         gap_viol = 0;
    logic [3:0] pat = 4'h0;
    int         pos = 0;
    logic       aligned_at_pop = 1'b0;
    logic       fail_at_pop = 1'b0;

    iserdes_1_to_4_align dut (
        .CLK        (CLK),
        .RST        (RST),
        .D          (D),
        .EN         (EN),
        .ALIGN_START(ALIGN_START),
        .Q          (Q),
        .DATA_VALID (DATA_VALID),
        .ALIGNED    (ALIGNED),
        .ALIGN_FAIL (ALIGN_FAIL),
        .SLIP_COUNT (SLIP_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, let the rising edge pass, sample on the fall.
    task automatic step(input logic d, input logic en, input logic start);
        logic [3:0] w;
        D           = d;
        EN          = en;
        ALIGN_START = start;
        @(posedge CLK);
        @(negedge CLK);
        ALIGN_START = 1'b0;
        if (DATA_VALID) begin
            dv_count++;
            if (!en) gap_viol++;
            if (sb_on) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", exp_q.size(), 1);
                end else begin
                    w = exp_q.pop_front();
                    check("word", Q, w);
                    aligned_at_pop = ALIGNED;
                    fail_at_pop    = ALIGN_FAIL;
                end
            end
        end
    endtask

    // Next stream bit (pat[0] first in time), optionally preceded by an EN gap.
    task automatic send_bit(input logic start);
        logic r;
        if (gaps && ($urandom_range(0, 2) == 0)) begin
            r = 1'($urandom_range(0, 1));
            step(r, 1'b0, 1'b0);
        end
        step(pat[pos[1:0]], 1'b1, start);
        pos++;
    endtask

    task automatic push_n(input logic [3:0] w, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(w);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; (i < budget) && (exp_q.size() != 0); i++) send_bit(1'b0);
        check("drain_words_left", exp_q.size(), 0);
    endtask

    task automatic apply_reset();
        sb_on = 1'b0;
        RST   = 1'b0;
        for (int i = 0; i < 3; i++) step(i[0], 1'b1, 1'b0);
        RST = 1'b1;
        pos = 0;
        exp_q.delete();
        gaps = 1'b0;
    endtask

    // Three mismatching offsets, then lock (stream 1,0,0,1,...).
    task automatic push_three_slip_seq();
        exp_q.push_back(4'b1001);
        push_n(4'b1100, 2);
        push_n(4'b0110, 2);
        push_n(4'b0011, 5);
    endtask

    initial begin
        // ---- 1: reset holds everything clear, then plain word assembly ----
        for (int i = 0; i < 4; i++) step(i[0], 1'b1, 1'b0);
        check("rst_q", Q, 0);
        check("rst_dv", DATA_VALID, 0);
        check("rst_aligned", ALIGNED, 0);
        check("rst_fail", ALIGN_FAIL, 0);
        check("rst_slip", SLIP_COUNT, 0);
        RST      = 1'b1;
        pos      = 0;
        pat      = 4'b1101;
        sb_on    = 1'b1;
        dv_count = 0;
        push_n(4'b1101, 3);
        send_bit(1'b0);
        check("dv_bit1", DATA_VALID, 0);
        send_bit(1'b0);
        send_bit(1'b0);
        check("dv_bit3", DATA_VALID, 0);
        send_bit(1'b0);
        check("dv_bit4", DATA_VALID, 1);
        check("q_first_word", Q, 4'b1101);
        send_bit(1'b0);
        check("dv_one_cycle", DATA_VALID, 0);
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        check("dv_every_4", dv_count, 3);
        check("words_left_s1", exp_q.size(), 0);

        // ---- 2: one-slip lock ----
        apply_reset();
        pat   = 4'b0110;
        sb_on = 1'b1;
        exp_q.push_back(4'b0110);
        push_n(4'b0011, 5);
        send_bit(1'b1);
        drain(100);
        check("s2_early_lock", aligned_at_pop, 0);
        send_bit(1'b0);
        check("s2_aligned", ALIGNED, 1);
        check("s2_slip", SLIP_COUNT, 1);
        check("s2_fail", ALIGN_FAIL, 0);

        // ---- 6a: restart while locked, relock without slips ----
        send_bit(1'b1);
        check("restart_locked_aligned", ALIGNED, 0);
        check("restart_locked_slip", SLIP_COUNT, 0);
        push_n(4'b0011, 4);
        drain(60);
        check("relock_early", aligned_at_pop, 0);
        send_bit(1'b0);
        check("relock_aligned", ALIGNED, 1);
        check("relock_slip", SLIP_COUNT, 0);

        // ---- 3: three-slip lock ----
        apply_reset();
        pat   = 4'b1001;
        sb_on = 1'b1;
        push_three_slip_seq();
        send_bit(1'b1);
        drain(150);
        check("s3_early_lock", aligned_at_pop, 0);
        send_bit(1'b0);
        check("s3_aligned", ALIGNED, 1);
        check("s3_slip", SLIP_COUNT, 3);
        check("s3_q", Q, 4'b0011);

        // ---- 4: no valid offset -> FAIL after exactly WIDTH slips ----
        apply_reset();
        pat   = 4'b1111;
        sb_on = 1'b1;
        push_n(4'b1111, 9);
        send_bit(1'b1);
        drain(150);
        check("s4_early_fail", fail_at_pop, 0);
        send_bit(1'b0);
        check("s4_fail", ALIGN_FAIL, 1);
        check("s4_aligned", ALIGNED, 0);
        check("s4_slip", SLIP_COUNT, 4);
        push_n(4'b1111, 3);
        dv_count = 0;
        for (int i = 0; i < 12; i++) send_bit(1'b0);
        check("s4_words_after_fail", dv_count, 3);
        check("s4_slip_frozen", SLIP_COUNT, 4);
        check("s4_words_left", exp_q.size(), 0);

        // ---- 5: scenario 3 with random EN gaps ----
        apply_reset();
        pat      = 4'b1001;
        gaps     = 1'b1;
        gap_viol = 0;
        sb_on    = 1'b1;
        push_three_slip_seq();
        send_bit(1'b1);
        drain(400);
        check("s5_early_lock", aligned_at_pop, 0);
        gaps = 1'b0;
        send_bit(1'b0);
        check("s5_aligned", ALIGNED, 1);
        check("s5_slip", SLIP_COUNT, 3);
        check("s5_dv_in_gap", gap_viol, 0);

        // ---- 6b: restart while a slip is pending cancels it ----
        apply_reset();
        pat   = 4'b1001;
        sb_on = 1'b1;
        exp_q.push_back(4'b1001);
        push_three_slip_seq();
        send_bit(1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        send_bit(1'b1);
        check("restart_slip_count", SLIP_COUNT, 0);
        check("restart_slip_aligned", ALIGNED, 0);
        drain(150);
        send_bit(1'b0);
        check("s6b_aligned", ALIGNED, 1);
        check("s6b_slip", SLIP_COUNT, 3);

        // ---- 6c: asynchronous reset mid-alignment, then stays idle ----
        apply_reset();
        pat = 4'b1111;
        send_bit(1'b1);
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        check("s6c_slip_before_rst", SLIP_COUNT, 1);
        check("s6c_q_before_rst", Q, 4'b1111);
        RST = 1'b0;
        #1;
        check("async_rst_q", Q, 0);
        check("async_rst_slip", SLIP_COUNT, 0);
        check("async_rst_dv", DATA_VALID, 0);
        check("async_rst_aligned", ALIGNED, 0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        RST      = 1'b1;
        pos      = 0;
        dv_count = 0;
        for (int i = 0; i < 16; i++) send_bit(1'b0);
        check("idle_no_slip", SLIP_COUNT, 0);
        check("idle_no_fail", ALIGN_FAIL, 0);
        check("idle_no_lock", ALIGNED, 0);
        check("idle_words", dv_count, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
